// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, handshakes with a variable-latency
// instruction memory, holds the fetched word for decode and applies redirects.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 16,
    parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSel,
    input  logic [31:0] alu_target,
    input  logic        inst_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        fault,
    output logic [1:0]  fault_code
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        FAULT
    } state_t;

    localparam int unsigned CW = (IMEM_TIMEOUT > 2) ? $clog2(IMEM_TIMEOUT) : 1;

    state_t        state, state_next;
    logic [31:0]   pc_q, pc_next;
    logic [31:0]   inst_q, inst_next;
    logic [1:0]    code_q, code_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [31:0]   target;
    logic          timeout_hit;

    assign pc_plus4    = pc_q + 32'd4;
    // JALR semantics: bit 0 of the ALU target is always dropped
    assign target      = PCSel ? (alu_target & ~32'h0000_0001) : pc_plus4;
    assign timeout_hit = (IMEM_TIMEOUT != 0) && (cnt == CW'(IMEM_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pc_q   <= RESET_PC;
            inst_q <= NOP_INST;
            code_q <= 2'b00;
            cnt    <= '0;
        end else begin
            state  <= state_next;
            pc_q   <= pc_next;
            inst_q <= inst_next;
            code_q <= code_next;
            cnt    <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        inst_next  = inst_q;
        code_next  = code_q;
        cnt_next   = cnt;

        unique case (state)
            IDLE: begin
                state_next = REQ;
            end

            REQ: begin
                // A response on the timeout edge still wins over the fault
                if (imem_ready) begin
                    inst_next  = imem_rdata;
                    cnt_next   = '0;
                    state_next = HOLD;
                end else if (timeout_hit) begin
                    code_next  = 2'b01;
                    state_next = FAULT;
                end else if (IMEM_TIMEOUT != 0) begin
                    cnt_next = cnt + CW'(1);
                end
            end

            HOLD: begin
                if (inst_ack) begin
                    if (target[1]) begin
                        code_next  = 2'b10;
                        state_next = FAULT;
                    end else begin
                        pc_next    = target;
                        inst_next  = NOP_INST;
                        state_next = REQ;
                    end
                end
            end

            FAULT: begin
                state_next = FAULT;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state so reset drops imem_req at once
    assign imem_req   = (state == REQ);
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign inst_valid = (state == HOLD);
    assign inst       = inst_valid ? inst_q : NOP_INST;
    assign fault      = (state == FAULT);
    assign fault_code = code_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: vector table of fetch/redirect
// transactions plus hand sequences for timeout and mid-request reset.
module tb_inst_fetch_unit;

    localparam logic [31:0] RPC = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSel;
    logic [31:0] alu_target;
    logic        inst_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fault;
    logic [1:0]  fault_code;

    inst_fetch_unit #(
        .RESET_PC    (RPC),
        .IMEM_TIMEOUT(4),
        .NOP_INST    (NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .PCSel     (PCSel),
        .alu_target(alu_target),
        .inst_ack  (inst_ack),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .inst      (inst),
        .inst_valid(inst_valid),
        .fault     (fault),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        int          waits;
        int          hold;
        logic        sel;
        logic [31:0] tgt;
        logic [31:0] fetch_pc;
        logic [31:0] next_pc;
        logic [1:0]  code;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0F0F;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        PCSel      = 1'b0;
        alu_target = '0;
        inst_ack   = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = '0;
        step();
        step();
        check("rst_pc", pc, RPC);
        check("rst_pc_plus4", pc_plus4, 32'h0000_0000);
        check("rst_inst", inst, NOP);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_fault_code", 32'(fault_code), 32'd0);
        rst = 1'b0;
        check("idle_imem_req", 32'(imem_req), 32'd0);
        step();
        check("first_req", 32'(imem_req), 32'd1);
        check("first_req_addr", imem_addr, RPC);
    endtask

    // Memory side: hold off for 'waits' cycles, then return the word
    task automatic fetch(input int waits, input logic [31:0] exp_pc);
        sb_t got;
        for (int w = 0; w < waits; w++) begin
            imem_ready = 1'b0;
            check("wait_req", 32'(imem_req), 32'd1);
            check("wait_addr", imem_addr, exp_pc);
            check("wait_valid", 32'(inst_valid), 32'd0);
            step();
        end
        imem_ready = 1'b1;
        imem_rdata = mem_word(exp_pc);
        check("resp_req", 32'(imem_req), 32'd1);
        check("resp_addr", imem_addr, exp_pc);
        sb_q.push_back('{pc: exp_pc, word: mem_word(exp_pc)});
        step();
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check("hold_valid", 32'(inst_valid), 32'd1);
        check("hold_req", 32'(imem_req), 32'd0);
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            got = sb_q.pop_front();
            check("sb_inst", inst, got.word);
            check("sb_pc", pc, got.pc);
        end
    endtask

    task automatic ack(input logic sel, input logic [31:0] tgt, input logic [31:0] old_pc,
                       input logic [31:0] exp_next, input logic [1:0] code);
        PCSel      = sel;
        alu_target = tgt;
        inst_ack   = 1'b1;
        step();
        inst_ack   = 1'b0;
        PCSel      = 1'($urandom);
        alu_target = $urandom;
        if (code == 2'b00) begin
            check("ack_pc", pc, exp_next);
            check("ack_pc_plus4", pc_plus4, exp_next + 32'd4);
            check("ack_valid", 32'(inst_valid), 32'd0);
            check("ack_inst_nop", inst, NOP);
            check("ack_req", 32'(imem_req), 32'd1);
            check("ack_fault", 32'(fault), 32'd0);
        end else begin
            check("mis_fault", 32'(fault), 32'd1);
            check("mis_code", 32'(fault_code), 32'(code));
            check("mis_pc", pc, old_pc);
            check("mis_req", 32'(imem_req), 32'd0);
            check("mis_valid", 32'(inst_valid), 32'd0);
            check("mis_inst", inst, NOP);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        //           waits hold sel tgt            fetch_pc       next_pc        code
        vecs[0] = '{0, 0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 2'd0};
        vecs[1] = '{0, 0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 2'd0};
        vecs[2] = '{0, 0, 1'b0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 2'd0};
        vecs[3] = '{0, 0, 1'b0, 32'h0000_0666, 32'h0000_0008, 32'h0000_000C, 2'd0};
        vecs[4] = '{0, 0, 1'b0, 32'h0000_0102, 32'h0000_000C, 32'h0000_0010, 2'd0};
        vecs[5] = '{3, 0, 1'b0, 32'h0000_0000, 32'h0000_0010, 32'h0000_0014, 2'd0};
        vecs[6] = '{1, 2, 1'b1, 32'h0000_0020, 32'h0000_0014, 32'h0000_0020, 2'd0};
        vecs[7] = '{0, 0, 1'b1, 32'h0000_0101, 32'h0000_0020, 32'h0000_0100, 2'd0};
        vecs[8] = '{2, 1, 1'b1, 32'h0000_0021, 32'h0000_0100, 32'h0000_0020, 2'd0};
        vecs[9] = '{0, 0, 1'b1, 32'h0000_0102, 32'h0000_0020, 32'h0000_0020, 2'd2};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            fetch(vecs[i].waits, vecs[i].fetch_pc);
            check("hold_pc_plus4", pc_plus4, vecs[i].fetch_pc + 32'd4);
            for (int h = 0; h < vecs[i].hold; h++) begin
                imem_ready = 1'b1;
                imem_rdata = $urandom;
                step();
                check("stable_valid", 32'(inst_valid), 32'd1);
                check("stable_inst", inst, mem_word(vecs[i].fetch_pc));
                check("stable_pc", pc, vecs[i].fetch_pc);
            end
            imem_ready = 1'b0;
            ack(vecs[i].sel, vecs[i].tgt, vecs[i].fetch_pc, vecs[i].next_pc, vecs[i].code);
        end

        // FAULT is sticky: acks and responses have no effect
        inst_ack   = 1'b1;
        imem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("sticky_fault", 32'(fault), 32'd1);
            check("sticky_code", 32'(fault_code), 32'd2);
            check("sticky_pc", pc, 32'h0000_0020);
            check("sticky_req", 32'(imem_req), 32'd0);
        end
        inst_ack   = 1'b0;
        imem_ready = 1'b0;

        // Memory timeout after four unanswered REQ cycles
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            check("to_pending_fault", 32'(fault), 32'd0);
            check("to_pending_req", 32'(imem_req), 32'd1);
        end
        step();
        check("to_fault", 32'(fault), 32'd1);
        check("to_code", 32'(fault_code), 32'd1);
        check("to_req", 32'(imem_req), 32'd0);
        check("to_pc", pc, RPC);
        check("to_valid", 32'(inst_valid), 32'd0);
        imem_ready = 1'b1;
        imem_rdata = 32'h1234_5678;
        step();
        step();
        check("to_sticky", 32'(fault), 32'd1);
        check("to_sticky_inst", inst, NOP);
        do_reset();
        fetch(0, RPC);
        ack(1'b0, 32'h0, RPC, 32'h0000_0000, 2'd0);

        // Reset mid-REQ; a response during reset must be ignored
        do_reset();
        step();
        check("mid_req_before", 32'(imem_req), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_req_dropped", 32'(imem_req), 32'd0);
        check("mid_pc", pc, RPC);
        imem_ready = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        step();
        rst        = 1'b0;
        imem_ready = 1'b0;
        check("mid_ignored_valid", 32'(inst_valid), 32'd0);
        check("mid_ignored_inst", inst, NOP);
        check("mid_idle_req", 32'(imem_req), 32'd0);
        step();
        check("mid_restart_req", 32'(imem_req), 32'd1);
        check("mid_restart_addr", imem_addr, RPC);
        fetch(1, RPC);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
